// File: rtl/route4.sv
// route4: one-input, four-output word router.
// Each output port owns an independent 2-entry FIFO. The input word is steered
// to the FIFO named by in_select and is visible on that port one edge later.
// Per-port delivery counters count pops and wrap at 16 bits.
module route4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_select,

    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,

    output logic [7:0]       out_count,
    output logic [15:0]      deliv_cnt0,
    output logic [15:0]      deliv_cnt1,
    output logic [15:0]      deliv_cnt2,
    output logic [15:0]      deliv_cnt3
);

    // Occupancy of the FIFO currently addressed by in_select.
    logic [1:0] sel_occ;

    // Single accept strobe; each port qualifies it with its own index.
    logic       accept;

    // Select the occupancy of the addressed port.
    always_comb begin
        sel_occ = 2'd0;
        unique case (in_select)
            2'd0:    sel_occ = g_port[0].occ_q;
            2'd1:    sel_occ = g_port[1].occ_q;
            2'd2:    sel_occ = g_port[2].occ_q;
            default: sel_occ = g_port[3].occ_q;
        endcase
    end

    // Ready depends only on the addressed FIFO's registered occupancy, never
    // on out_ready, so a full port cannot pass a word through in one cycle.
    always_comb begin
        in_ready = 1'b0;
        accept   = 1'b0;
        if (!reset) begin
            in_ready = (sel_occ < 2'd2);
        end
        accept = in_valid && in_ready;
    end

    for (genvar p = 0; p < 4; p++) begin : g_port
        // Head is the word presented on the port; tail is the second entry.
        // An entry that is not valid is always held at zero.
        logic [WIDTH-1:0] head_q;
        logic [WIDTH-1:0] tail_q;
        logic [1:0]       occ_q;
        logic [15:0]      cnt_q;
        logic             push;
        logic             pop;
        logic             valid;
        logic [WIDTH-1:0] head_out;

        // Per-port push/pop qualification and head presentation.
        always_comb begin
            valid    = (occ_q != 2'd0);
            push     = accept && (in_select == 2'(p));
            pop      = valid && out_ready[p];
            head_out = '0;
            if (valid) begin
                head_out = head_q;
            end
        end

        // FIFO storage, occupancy and delivery counter; reset overrides any
        // push or pop presented at the same edge.
        always_ff @(posedge clk) begin
            if (reset) begin
                head_q <= '0;
                tail_q <= '0;
                occ_q  <= 2'd0;
                cnt_q  <= '0;
            end else begin
                unique case ({push, pop})
                    2'b10: begin
                        if (occ_q == 2'd0) begin
                            head_q <= in_data;
                        end else begin
                            tail_q <= in_data;
                        end
                        occ_q <= occ_q + 2'd1;
                    end
                    2'b01: begin
                        head_q <= tail_q;
                        tail_q <= '0;
                        occ_q  <= occ_q - 2'd1;
                        cnt_q  <= cnt_q + 16'd1;
                    end
                    2'b11: begin
                        // Occupancy unchanged: with one word the new word
                        // becomes head; with two the queue shifts by one.
                        if (occ_q == 2'd1) begin
                            head_q <= in_data;
                        end else begin
                            head_q <= tail_q;
                            tail_q <= in_data;
                        end
                        cnt_q <= cnt_q + 16'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Map per-port state onto the flat output ports.
    always_comb begin
        out_valid  = {g_port[3].valid, g_port[2].valid,
                      g_port[1].valid, g_port[0].valid};
        out_count  = {g_port[3].occ_q, g_port[2].occ_q,
                      g_port[1].occ_q, g_port[0].occ_q};
        out_data0  = g_port[0].head_out;
        out_data1  = g_port[1].head_out;
        out_data2  = g_port[2].head_out;
        out_data3  = g_port[3].head_out;
        deliv_cnt0 = g_port[0].cnt_q;
        deliv_cnt1 = g_port[1].cnt_q;
        deliv_cnt2 = g_port[2].cnt_q;
        deliv_cnt3 = g_port[3].cnt_q;
    end

endmodule

// File: tb/tb_route4.sv
// Directed self-checking bench for route4.
module tb_route4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_select;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [7:0]  out_count;
    logic [15:0] deliv_cnt0, deliv_cnt1, deliv_cnt2, deliv_cnt3;

    int errors = 0;
    int checks = 0;

    route4 #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_select  (in_select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .out_count  (out_count),
        .deliv_cnt0 (deliv_cnt0),
        .deliv_cnt1 (deliv_cnt1),
        .deliv_cnt2 (deliv_cnt2),
        .deliv_cnt3 (deliv_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are changed and outputs sampled 1 after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 4'b0000;
        in_data = '0; in_select = 2'd0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 4'b0000;
        in_data = '0; in_select = 2'd0;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
        checks++; if (out_count !== 8'h00) begin errors++; $display("FAIL reset_out_count got=%h exp=00", out_count); end
        checks++; if ({out_data0, out_data1, out_data2, out_data3} !== 128'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", {out_data0, out_data1, out_data2, out_data3}); end
        checks++; if ({deliv_cnt0, deliv_cnt1, deliv_cnt2, deliv_cnt3} !== 64'h0) begin errors++; $display("FAIL reset_deliv got=%h exp=0", {deliv_cnt0, deliv_cnt1, deliv_cnt2, deliv_cnt3}); end
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            in_select = 2'(s);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready sel=%0d got=%b exp=1", s, in_ready); end
        end
    endtask

    task automatic test_single_route();
        do_reset();
        in_valid = 1'b1; in_select = 2'd2; in_data = 32'hA5A5_0001;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid got=%b exp=0100", out_valid); end
        checks++; if (out_data2 !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data got=%h exp=a5a50001", out_data2); end
        checks++; if (out_count !== 8'b0001_0000) begin errors++; $display("FAIL single_count got=%b exp=00010000", out_count); end
        checks++; if (out_data0 !== 32'h0) begin errors++; $display("FAIL single_empty_data0 got=%h exp=0", out_data0); end
        out_ready = 4'b0100;
        tick();
        out_ready = 4'b0000;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_drained got=%b exp=0000", out_valid); end
        checks++; if (deliv_cnt2 !== 16'd1) begin errors++; $display("FAIL single_deliv got=%0d exp=1", deliv_cnt2); end
        checks++; if (out_data2 !== 32'h0) begin errors++; $display("FAIL single_empty_data2 got=%h exp=0", out_data2); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; in_select = 2'd1; in_data = 32'h11;
        tick();
        in_data = 32'h12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2 got=%b exp=1", in_ready); end
        tick();
        in_data = 32'h13;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready3 got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_count[3:2] !== 2'd2) begin errors++; $display("FAIL bp_count got=%0d exp=2", out_count[3:2]); end
        checks++; if (out_data1 !== 32'h11) begin errors++; $display("FAIL bp_head1 got=%h exp=11", out_data1); end
        out_ready = 4'b0010;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_passthru got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_data1 !== 32'h12) begin errors++; $display("FAIL bp_head2 got=%h exp=12", out_data1); end
        checks++; if (out_count[3:2] !== 2'd1) begin errors++; $display("FAIL bp_count1 got=%0d exp=1", out_count[3:2]); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_data1 !== 32'h13) begin errors++; $display("FAIL bp_head3 got=%h exp=13", out_data1); end
        checks++; if (out_count[3:2] !== 2'd1) begin errors++; $display("FAIL bp_count_pp got=%0d exp=1", out_count[3:2]); end
        tick();
        out_ready = 4'b0000;
        checks++; if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", out_valid[1]); end
        checks++; if (deliv_cnt1 !== 16'd3) begin errors++; $display("FAIL bp_deliv got=%0d exp=3", deliv_cnt1); end
    endtask

    task automatic test_push_pop();
        do_reset();
        in_valid = 1'b1; in_select = 2'd0; in_data = 32'h1;
        tick();
        in_data = 32'h2; out_ready = 4'b0001;
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        checks++; if (out_count[1:0] !== 2'd1) begin errors++; $display("FAIL pp_count got=%0d exp=1", out_count[1:0]); end
        checks++; if (out_data0 !== 32'h2) begin errors++; $display("FAIL pp_data got=%h exp=2", out_data0); end
        checks++; if (deliv_cnt0 !== 16'd1) begin errors++; $display("FAIL pp_deliv got=%0d exp=1", deliv_cnt0); end
    endtask

    task automatic test_isolation();
        do_reset();
        in_valid = 1'b1; in_select = 2'd3; in_data = 32'h31;
        tick();
        in_data = 32'h32;
        tick();
        in_data = 32'h33;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL iso_p3_full got=%b exp=0", in_ready); end
        for (int s = 0; s < 3; s++) begin
            in_select = 2'(s); in_data = 32'h40 + 32'(s);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL iso_ready sel=%0d got=%b exp=1", s, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_count !== 8'b10_01_01_01) begin errors++; $display("FAIL iso_count got=%b exp=10010101", out_count); end
        checks++; if (out_data3 !== 32'h31) begin errors++; $display("FAIL iso_p3 got=%h exp=31", out_data3); end
        checks++; if ({out_data0, out_data1, out_data2} !== {32'h40, 32'h41, 32'h42}) begin errors++; $display("FAIL iso_heads got=%h exp=000000400000004100000042", {out_data0, out_data1, out_data2}); end
        checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL iso_valid got=%b exp=1111", out_valid); end
    endtask

    task automatic test_reset_mid();
        // Ports all hold words from the isolation scenario; push and pop are
        // presented together with reset.
        in_valid = 1'b1; in_select = 2'd0; in_data = 32'hDEAD; out_ready = 4'b1111;
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rm_valid got=%b exp=0000", out_valid); end
        checks++; if (out_count !== 8'h00) begin errors++; $display("FAIL rm_count got=%h exp=00", out_count); end
        checks++; if ({deliv_cnt0, deliv_cnt1, deliv_cnt2, deliv_cnt3} !== 64'h0) begin errors++; $display("FAIL rm_deliv got=%h exp=0", {deliv_cnt0, deliv_cnt1, deliv_cnt2, deliv_cnt3}); end
        tick();
        out_ready = 4'b0000;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rm_stale got=%b exp=0000", out_valid); end
        checks++; if ({out_data0, out_data1, out_data2, out_data3} !== 128'h0) begin errors++; $display("FAIL rm_data got=%h exp=0", {out_data0, out_data1, out_data2, out_data3}); end
        checks++; if ({deliv_cnt0, deliv_cnt1, deliv_cnt2, deliv_cnt3} !== 64'h0) begin errors++; $display("FAIL rm_ready_no_valid got=%h exp=0", {deliv_cnt0, deliv_cnt1, deliv_cnt2, deliv_cnt3}); end
    endtask

    task automatic test_counter_wrap();
        // First edge is a push only; each later edge pushes and pops, so
        // after edge k (0-based) the pop count is k.
        do_reset();
        in_valid = 1'b1; in_select = 2'd2; out_ready = 4'b0100;
        for (int k = 0; k <= 65537; k++) begin
            in_data = 32'(k);
            tick();
            if (k == 65535) begin
                checks++; if (deliv_cnt2 !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got=%h exp=ffff", deliv_cnt2); end
            end
        end
        in_valid = 1'b0; out_ready = 4'b0000;
        checks++; if (deliv_cnt2 !== 16'h0001) begin errors++; $display("FAIL wrap_cnt got=%h exp=0001", deliv_cnt2); end
        checks++; if (out_data2 !== 32'd65537) begin errors++; $display("FAIL wrap_order got=%0d exp=65537", out_data2); end
        checks++; if (out_count !== 8'b0001_0000) begin errors++; $display("FAIL wrap_occ got=%b exp=00010000", out_count); end
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_backpressure();
        test_push_pop();
        test_isolation();
        test_reset_mid();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/route4.md
ROUTE4 -- requirements
Module: route4

Interface
REQ-001 Parameter WIDTH, default 32, data width of input and every output port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  input word present.
REQ-005 in_ready  output  1  route4 can accept the input word this cycle.
REQ-006 in_data  input  WIDTH  input word.
REQ-007 in_select  input  2  destination port (0..3), qualified by in_valid.
REQ-008 out_valid  output  4  bit i: port i has a word at its head.
REQ-009 out_ready  input  4  bit i: consumer of port i takes the head word.
REQ-010 out_data0, out_data1, out_data2, out_data3  output  WIDTH each  head word of port i.
REQ-011 out_count  output  8  4 x 2-bit occupancy fields, bits [2i+1:2i] = words held for port i (0..2).
REQ-012 deliv_cnt0..deliv_cnt3  output  16 each  words delivered on port i, wrapping.

Function
REQ-013 Each port i SHALL own an independent 2-entry FIFO; no storage is shared between ports.
REQ-014 Accept: in_valid=1 and in_ready=1 at a rising edge SHALL push in_data into FIFO[in_select].
REQ-015 in_ready SHALL be combinational: 0 while reset=1, otherwise 1 exactly when FIFO[in_select] holds fewer than 2 words.
REQ-016 in_ready SHALL NOT depend on out_ready (no same-cycle pass-through when full).
REQ-017 Deliver: out_valid[i]=1 and out_ready[i]=1 at a rising edge SHALL pop the head of FIFO[i].
REQ-018 out_valid[i] SHALL be 1 exactly when FIFO[i] occupancy is nonzero; out_data_i SHALL equal the head word, and 0 when empty.
REQ-019 Latency: a word accepted at edge N SHALL be visible on its port (out_valid=1) from immediately after edge N, i.e. 1 cycle after presentation.
REQ-020 Ordering: words to the same port SHALL be delivered in acceptance order; no ordering between ports.
REQ-021 Simultaneous push and pop on the same port: occupancy unchanged; when occupancy=1 the pushed word becomes head after the edge.
REQ-022 Pops on any subset of ports and one push SHALL all occur in the same cycle without interference.
REQ-023 out_ready[i]=1 with out_valid[i]=0 SHALL have no effect.
REQ-024 in_select changes while in_valid=0 SHALL have no effect; in_ready tracks the currently presented in_select.
REQ-025 out_count fields SHALL reflect registered occupancy after each edge.
REQ-026 deliv_cnt_i SHALL increment by 1 per pop on port i and wrap 16'hFFFF -> 16'h0000.
REQ-027 A word SHALL never be dropped or duplicated; pushes never occur to a full FIFO.

Reset
REQ-028 reset=1 at an edge SHALL empty all FIFOs, clear out_valid to 4'b0000, out_data0..3 to 0, out_count to 0, deliv_cnt0..3 to 0.
REQ-029 reset asserted mid-operation SHALL discard all buffered words; no pop or push is performed at that edge and deliv_cnt does not increment.
REQ-030 After reset deasserts, in_ready SHALL be 1 for any in_select on the first cycle.

Verification
REQ-031 Single route: reset, push 32'hA5A5_0001 with in_select=2, out_ready=0 -> next cycle out_valid=4'b0100, out_data2=32'hA5A5_0001, out_count=8'b0001_0000.
REQ-032 Full/backpressure: push 3 words to port 1 with out_ready=0 -> first two accepted, in_ready=0 for third, out_count[3:2]=2; raise out_ready[1] -> words drained in order, third then accepted.
REQ-033 Simultaneous push/pop: port 0 holds 1 word, push 32'h2 to port 0 while out_ready[0]=1 -> occupancy stays 1, out_data0=32'h2 next cycle, deliv_cnt0 +1.
REQ-034 Isolation: port 3 full and stalled, push to ports 0..2 -> all accepted, port 3 contents unchanged.
REQ-035 Reset mid-operation: ports 0 and 1 holding words, reset=1 one cycle -> out_valid=0, out_count=0, deliv_cnt0..3=0, stale words never appear.
REQ-036 Counter wrap: 65537 pops on port 2 -> deliv_cnt2=16'h0001.
